// File: rtl/alu_seq_if.sv
// Execute-stage handshake bundle for alu_seq: request fields with start,
// and busy/done/branch/ALU_result coming back from the ALU.
interface alu_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [5:0]            ALU_Control;
    logic [DATA_WIDTH-1:0] operand_A;
    logic [DATA_WIDTH-1:0] operand_B;
    logic                  branch_op;
    logic                  busy;
    logic                  done;
    logic                  branch;
    logic [DATA_WIDTH-1:0] ALU_result;

    modport master (
        output start, ALU_Control, operand_A, operand_B, branch_op,
        input  busy, done, branch, ALU_result
    );

    modport slave (
        input  start, ALU_Control, operand_A, operand_B, branch_op,
        output busy, done, branch, ALU_result
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle RV32I/M execute ALU: single-cycle ops resolve straight to RESP,
// mul/div iterate one bit per cycle through a shared hi/lo shift register.
module alu_seq #(
    parameter int DATA_WIDTH = 32
) (
    input logic      clock,
    input logic      reset,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b001000;
    localparam logic [5:0] OP_SLT   = 6'b000010;
    localparam logic [5:0] OP_SLTU  = 6'b000011;
    localparam logic [5:0] OP_XOR   = 6'b000100;
    localparam logic [5:0] OP_OR    = 6'b000110;
    localparam logic [5:0] OP_AND   = 6'b000111;
    localparam logic [5:0] OP_SLL   = 6'b000001;
    localparam logic [5:0] OP_SRL   = 6'b000101;
    localparam logic [5:0] OP_SRA   = 6'b001101;
    localparam logic [5:0] OP_JAL   = 6'b011111;
    localparam logic [5:0] OP_JALR  = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b010000;
    localparam logic [5:0] OP_BNE   = 6'b010001;
    localparam logic [5:0] OP_BLT   = 6'b010100;
    localparam logic [5:0] OP_BGE   = 6'b010101;
    localparam logic [5:0] OP_BLTU  = 6'b010110;
    localparam logic [5:0] OP_BGEU  = 6'b010111;
    localparam logic [5:0] OP_MUL   = 6'b100000;
    localparam logic [5:0] OP_MULHU = 6'b100011;
    localparam logic [5:0] OP_DIV   = 6'b100100;
    localparam logic [5:0] OP_DIVU  = 6'b100101;
    localparam logic [5:0] OP_REM   = 6'b100110;
    localparam logic [5:0] OP_REMU  = 6'b100111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_RESP
    } state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] b_q;
    logic [5:0]            op_q;
    logic                  neg_q;
    logic                  neg_r;
    logic                  busy_q;
    logic                  done_q;
    logic                  branch_q;
    logic [DATA_WIDTH-1:0] result_q;

    logic [5:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [CW-1:0]         shamt;
    logic                  eq;
    logic                  lt_s;
    logic                  lt_u;
    logic                  cond;
    logic                  div_signed;
    logic                  a_neg;
    logic                  b_neg;
    logic                  div_ovf;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic [DATA_WIDTH-1:0] sc_result;
    logic                  sc_branch;
    logic                  iterate;
    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH:0]   div_shift;
    logic [DATA_WIDTH:0]   div_diff;
    logic [DATA_WIDTH-1:0] fix_result;

    assign op    = bus.ALU_Control;
    assign a     = bus.operand_A;
    assign b     = bus.operand_B;
    assign shamt = b[CW-1:0];
    assign eq    = (a == b);
    assign lt_s  = ($signed(a) < $signed(b));
    assign lt_u  = (a < b);

    // Only div/rem work on magnitudes; mul ops see the raw operands.
    assign div_signed = (op[5:2] == 4'b1001) && !op[0];
    assign a_neg      = div_signed & a[DATA_WIDTH-1];
    assign b_neg      = div_signed & b[DATA_WIDTH-1];
    assign a_mag      = a_neg ? '0 - a : a;
    assign b_mag      = b_neg ? '0 - b : b;
    assign div_ovf    = div_signed && (a == MIN_VAL) && (b == '1);

    always_comb begin
        case (op[2:0])
            3'b000:  cond = eq;
            3'b001:  cond = ~eq;
            3'b100:  cond = lt_s;
            3'b101:  cond = ~lt_s;
            3'b110:  cond = lt_u;
            3'b111:  cond = ~lt_u;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        sc_result = '0;
        sc_branch = 1'b0;
        iterate   = 1'b0;
        case (op)
            OP_ADD:  sc_result = a + b;
            OP_SUB:  sc_result = a - b;
            OP_SLT:  sc_result = DATA_WIDTH'(lt_s);
            OP_SLTU: sc_result = DATA_WIDTH'(lt_u);
            OP_XOR:  sc_result = a ^ b;
            OP_OR:   sc_result = a | b;
            OP_AND:  sc_result = a & b;
            OP_SLL:  sc_result = a << shamt;
            OP_SRL:  sc_result = a >> shamt;
            OP_SRA:  sc_result = $signed(a) >>> shamt;
            OP_JAL, OP_JALR: begin
                sc_result = a;
                sc_branch = bus.branch_op;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                sc_result = DATA_WIDTH'(cond);
                sc_branch = bus.branch_op & cond;
            end
            OP_MUL, OP_MULHU: iterate = 1'b1;
            OP_DIV, OP_DIVU: begin
                if (b == '0)  sc_result = '1;
                else if (div_ovf) sc_result = MIN_VAL;
                else          iterate = 1'b1;
            end
            OP_REM, OP_REMU: begin
                if (b == '0)  sc_result = a;
                else if (div_ovf) sc_result = '0;
                else          iterate = 1'b1;
            end
            default: ;
        endcase
    end

    // hi:lo is the product for mul, remainder:quotient for div.
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    assign div_shift = {hi, lo[DATA_WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};

    always_comb begin
        case (op_q)
            OP_MUL:          fix_result = lo;
            OP_MULHU:        fix_result = hi;
            OP_DIV, OP_DIVU: fix_result = neg_q ? '0 - lo : lo;
            OP_REM, OP_REMU: fix_result = neg_r ? '0 - hi : hi;
            default:         fix_result = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            b_q      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            branch_q <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE, S_RESP: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                    if (bus.start) begin
                        if (iterate) begin
                            state  <= S_ITER;
                            busy_q <= 1'b1;
                            count  <= '0;
                            op_q   <= op;
                            hi     <= '0;
                            lo     <= a_mag;
                            b_q    <= b_mag;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                        end else begin
                            state    <= S_RESP;
                            done_q   <= 1'b1;
                            result_q <= sc_result;
                            branch_q <= sc_branch;
                        end
                    end
                end
                S_ITER: begin
                    if (op_q[2]) begin
                        if (!div_diff[DATA_WIDTH]) begin
                            hi <= div_diff[DATA_WIDTH-1:0];
                            lo <= {lo[DATA_WIDTH-2:0], 1'b1};
                        end else begin
                            hi <= div_shift[DATA_WIDTH-1:0];
                            lo <= {lo[DATA_WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hi <= mul_sum[DATA_WIDTH:1];
                        lo <= {mul_sum[0], lo[DATA_WIDTH-1:1]};
                    end
                    if (count == LAST) begin
                        count <= '0;
                        state <= S_FIX;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                S_FIX: begin
                    result_q <= fix_result;
                    branch_q <= 1'b0;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.branch     = branch_q;
    assign bus.ALU_result = result_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit instance for the full op set and a
// 16-bit instance for the width-scaled multi-cycle latency.
module tb_alu_seq;
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b001000;
    localparam logic [5:0] OP_SLT   = 6'b000010;
    localparam logic [5:0] OP_SLTU  = 6'b000011;
    localparam logic [5:0] OP_XOR   = 6'b000100;
    localparam logic [5:0] OP_OR    = 6'b000110;
    localparam logic [5:0] OP_AND   = 6'b000111;
    localparam logic [5:0] OP_SLL   = 6'b000001;
    localparam logic [5:0] OP_SRL   = 6'b000101;
    localparam logic [5:0] OP_SRA   = 6'b001101;
    localparam logic [5:0] OP_JAL   = 6'b011111;
    localparam logic [5:0] OP_JALR  = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b010000;
    localparam logic [5:0] OP_BNE   = 6'b010001;
    localparam logic [5:0] OP_BLT   = 6'b010100;
    localparam logic [5:0] OP_BGE   = 6'b010101;
    localparam logic [5:0] OP_BLTU  = 6'b010110;
    localparam logic [5:0] OP_BGEU  = 6'b010111;
    localparam logic [5:0] OP_MUL   = 6'b100000;
    localparam logic [5:0] OP_MULHU = 6'b100011;
    localparam logic [5:0] OP_DIV   = 6'b100100;
    localparam logic [5:0] OP_DIVU  = 6'b100101;
    localparam logic [5:0] OP_REM   = 6'b100110;
    localparam logic [5:0] OP_REMU  = 6'b100111;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        bop;
        logic [31:0] res;
        logic        br;
        logic [7:0]  lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.DATA_WIDTH(32)) bus32();
    alu_seq_if #(.DATA_WIDTH(16)) bus16();

    alu_seq #(.DATA_WIDTH(32)) dut32 (.clock(clk), .reset(rst), .bus(bus32.slave));
    alu_seq #(.DATA_WIDTH(16)) dut16 (.clock(clk), .reset(rst), .bus(bus16.slave));

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic bop, input logic [31:0] res, input logic br,
                                input logic [7:0] lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.bop = bop; v.res = res; v.br = br; v.lat = lat;
        return v;
    endfunction

    // Presents one request in cycle N; returns at #1 into cycle N+1.
    task automatic send32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic bop);
        @(negedge clk);
        bus32.start = 1'b1; bus32.ALU_Control = op;
        bus32.operand_A = a; bus32.operand_B = b; bus32.branch_op = bop;
        @(posedge clk); #1;
        bus32.start = 1'b0;
    endtask

    task automatic send16(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus16.start = 1'b1; bus16.ALU_Control = op;
        bus16.operand_A = a; bus16.operand_B = b; bus16.branch_op = 1'b0;
        @(posedge clk); #1;
        bus16.start = 1'b0;
    endtask

    // lat counts cycles after acceptance (1 = N+1); junk pokes ignored starts while busy.
    task automatic wait32(input logic junk, output int lat, output logic busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        while (bus32.done !== 1'b1 && lat < 60) begin
            if (bus32.busy !== 1'b1) busy_ok = 1'b0;
            if (junk) begin
                @(negedge clk);
                bus32.start = (lat % 4 == 1);
                bus32.ALU_Control = OP_ADD;
                bus32.operand_A = 32'h1111_1111;
                bus32.operand_B = 32'h2222_2222;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus32.start = 1'b0;
    endtask

    task automatic wait16(output int lat, output logic busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        while (bus16.done !== 1'b1 && lat < 60) begin
            if (bus16.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus32.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus32.busy); end
        checks++; if (bus32.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus32.done); end
        checks++; if (bus32.branch !== 1'b0) begin errors++; $display("FAIL reset_branch: got %b expected 0", bus32.branch); end
        checks++; if (bus32.ALU_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus32.ALU_result); end
        checks++; if (bus16.ALU_result !== 16'h0 || bus16.done !== 1'b0) begin
            errors++; $display("FAIL reset_w16: result %h done %b expected 0/0", bus16.ALU_result, bus16.done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add;
        send32(OP_ADD, 32'd4, 32'd5, 1'b0);
        checks++; if (bus32.done !== 1'b1) begin errors++; $display("FAIL add_done_n1: got %b expected 1", bus32.done); end
        checks++; if (bus32.ALU_result !== 32'd9) begin errors++; $display("FAIL add_result: got %h expected 9", bus32.ALU_result); end
        checks++; if (bus32.branch !== 1'b0) begin errors++; $display("FAIL add_branch: got %b expected 0", bus32.branch); end
        checks++; if (bus32.busy !== 1'b0) begin errors++; $display("FAIL add_busy: got %b expected 0", bus32.busy); end
        @(posedge clk); #1;
        checks++; if (bus32.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b expected 0", bus32.done); end
        checks++; if (bus32.ALU_result !== 32'd9) begin errors++; $display("FAIL add_hold: got %h expected 9", bus32.ALU_result); end
    endtask

    task automatic test_single;
        vec_t v[$];
        int   lat;
        logic bok;
        v.push_back(mk(OP_SLT,  32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, 32'h1,         1'b0, 8'd1));
        v.push_back(mk(OP_SLTU, 32'h4,         32'hFFFF_FFFF, 1'b0, 32'h1,         1'b0, 8'd1));
        v.push_back(mk(OP_SLT,  32'h5,         32'h3,         1'b0, 32'h0,         1'b0, 8'd1));
        v.push_back(mk(OP_SRA,  32'h8000_0000, 32'h4,         1'b0, 32'hF800_0000, 1'b0, 8'd1));
        v.push_back(mk(OP_SUB,  32'h5,         32'h7,         1'b0, 32'hFFFF_FFFE, 1'b0, 8'd1));
        v.push_back(mk(OP_ADD,  32'hFFFF_FFFF, 32'h2,         1'b1, 32'h1,         1'b0, 8'd1));
        v.push_back(mk(OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h0FF0_0FF0, 1'b0, 8'd1));
        v.push_back(mk(OP_OR,   32'h0F0F_0000, 32'h0000_00F0, 1'b0, 32'h0F0F_00F0, 1'b0, 8'd1));
        v.push_back(mk(OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000, 1'b0, 8'd1));
        v.push_back(mk(OP_SLL,  32'h1,         32'h23,        1'b0, 32'h8,         1'b0, 8'd1));
        v.push_back(mk(OP_SRL,  32'h8000_0000, 32'h1F,        1'b0, 32'h1,         1'b0, 8'd1));
        v.push_back(mk(OP_BGE,  32'h4,         32'h3,         1'b1, 32'h1,         1'b1, 8'd1));
        v.push_back(mk(OP_BGE,  32'h4,         32'h3,         1'b0, 32'h1,         1'b0, 8'd1));
        v.push_back(mk(OP_JALR, 32'h4,         32'h99,        1'b1, 32'h4,         1'b1, 8'd1));
        v.push_back(mk(OP_JAL,  32'h100,       32'h0,         1'b0, 32'h100,       1'b0, 8'd1));
        v.push_back(mk(OP_BEQ,  32'h5,         32'h5,         1'b1, 32'h1,         1'b1, 8'd1));
        v.push_back(mk(OP_BNE,  32'h5,         32'h5,         1'b1, 32'h0,         1'b0, 8'd1));
        v.push_back(mk(OP_BLT,  32'hFFFF_FFFF, 32'h1,         1'b1, 32'h1,         1'b1, 8'd1));
        v.push_back(mk(OP_BLTU, 32'hFFFF_FFFF, 32'h1,         1'b1, 32'h0,         1'b0, 8'd1));
        v.push_back(mk(OP_BGEU, 32'h1,         32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0, 8'd1));
        v.push_back(mk(6'b001111, 32'h3,       32'h4,         1'b1, 32'h0,         1'b0, 8'd1));
        foreach (v[i]) begin
            send32(v[i].op, v[i].a, v[i].b, v[i].bop);
            wait32(1'b0, lat, bok);
            checks++; if (lat !== 1) begin errors++; $display("FAIL single[%0d]_latency: got %0d expected 1", i, lat); end
            checks++; if (bus32.ALU_result !== v[i].res) begin errors++; $display("FAIL single[%0d]_result: got %h expected %h", i, bus32.ALU_result, v[i].res); end
            checks++; if (bus32.branch !== v[i].br) begin errors++; $display("FAIL single[%0d]_branch: got %b expected %b", i, bus32.branch, v[i].br); end
            checks++; if (bus32.busy !== 1'b0) begin errors++; $display("FAIL single[%0d]_busy: got %b expected 0", i, bus32.busy); end
        end
    endtask

    task automatic test_back_to_back;
        vec_t v[$];
        v.push_back(mk(OP_ADD, 32'd1,         32'd2, 1'b0, 32'd3,  1'b0, 8'd1));
        v.push_back(mk(OP_SUB, 32'd10,        32'd3, 1'b0, 32'd7,  1'b0, 8'd1));
        v.push_back(mk(OP_SLT, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd1,  1'b0, 8'd1));
        v.push_back(mk(OP_JAL, 32'h40,        32'd0, 1'b1, 32'h40, 1'b1, 8'd1));
        foreach (v[i]) begin
            @(negedge clk);
            bus32.start = 1'b1; bus32.ALU_Control = v[i].op;
            bus32.operand_A = v[i].a; bus32.operand_B = v[i].b; bus32.branch_op = v[i].bop;
            @(posedge clk); #1;
            checks++; if (bus32.done !== 1'b1) begin errors++; $display("FAIL b2b[%0d]_done: got %b expected 1", i, bus32.done); end
            checks++; if (bus32.ALU_result !== v[i].res || bus32.branch !== v[i].br) begin
                errors++; $display("FAIL b2b[%0d]_result: got %h/%b expected %h/%b", i, bus32.ALU_result, bus32.branch, v[i].res, v[i].br);
            end
        end
        bus32.start = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus32.done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b expected 0", bus32.done); end
    endtask

    task automatic test_mul_div;
        vec_t v[$];
        int   lat;
        logic bok;
        v.push_back(mk(OP_MUL,   32'hFFFF_FFFF, 32'h3,         1'b1, 32'hFFFF_FFFD, 1'b0, 8'd34));
        v.push_back(mk(OP_MULHU, 32'hFFFF_FFFF, 32'h3,         1'b0, 32'h2,         1'b0, 8'd34));
        v.push_back(mk(OP_MUL,   32'h1234_5678, 32'h10,        1'b0, 32'h2345_6780, 1'b0, 8'd34));
        v.push_back(mk(OP_MULHU, 32'h1234_5678, 32'h10,        1'b0, 32'h1,         1'b0, 8'd34));
        v.push_back(mk(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 8'd34));
        v.push_back(mk(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h1,         1'b0, 8'd34));
        v.push_back(mk(OP_DIV,   32'hFFFF_FFF9, 32'h2,         1'b0, 32'hFFFF_FFFD, 1'b0, 8'd34));
        v.push_back(mk(OP_REM,   32'hFFFF_FFF9, 32'h2,         1'b0, 32'hFFFF_FFFF, 1'b0, 8'd34));
        v.push_back(mk(OP_DIV,   32'h7,         32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFD, 1'b0, 8'd34));
        v.push_back(mk(OP_REM,   32'h7,         32'hFFFF_FFFE, 1'b0, 32'h1,         1'b0, 8'd34));
        v.push_back(mk(OP_DIVU,  32'd100,       32'd7,         1'b0, 32'd14,        1'b0, 8'd34));
        v.push_back(mk(OP_REMU,  32'd100,       32'd7,         1'b0, 32'd2,         1'b0, 8'd34));
        v.push_back(mk(OP_DIV,   32'h8000_0000, 32'h1,         1'b0, 32'h8000_0000, 1'b0, 8'd34));
        v.push_back(mk(OP_REM,   32'h8000_0000, 32'h3,         1'b0, 32'hFFFF_FFFE, 1'b0, 8'd34));
        v.push_back(mk(OP_DIVU,  32'h7,         32'h0,         1'b0, 32'hFFFF_FFFF, 1'b0, 8'd1));
        v.push_back(mk(OP_REMU,  32'h7,         32'h0,         1'b0, 32'h7,         1'b0, 8'd1));
        v.push_back(mk(OP_DIV,   32'h8000_0000, 32'h0,         1'b0, 32'hFFFF_FFFF, 1'b0, 8'd1));
        v.push_back(mk(OP_REM,   32'hFFFF_FFF9, 32'h0,         1'b0, 32'hFFFF_FFF9, 1'b0, 8'd1));
        v.push_back(mk(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 8'd1));
        v.push_back(mk(OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, 8'd1));
        foreach (v[i]) begin
            send32(v[i].op, v[i].a, v[i].b, v[i].bop);
            wait32(1'b1, lat, bok);
            checks++; if (lat !== int'(v[i].lat)) begin errors++; $display("FAIL md[%0d]_latency: got %0d expected %0d", i, lat, v[i].lat); end
            checks++; if (bus32.ALU_result !== v[i].res) begin errors++; $display("FAIL md[%0d]_result: got %h expected %h", i, bus32.ALU_result, v[i].res); end
            checks++; if (bus32.branch !== 1'b0) begin errors++; $display("FAIL md[%0d]_branch: got %b expected 0", i, bus32.branch); end
            checks++; if (bok !== 1'b1 || bus32.busy !== 1'b0) begin
                errors++; $display("FAIL md[%0d]_busy: held %b at_done %b expected 1/0", i, bok, bus32.busy);
            end
        end
    endtask

    task automatic test_reset_mid_op;
        logic quiet = 1'b1;
        send32(OP_ADD, 32'd3, 32'd4, 1'b0);
        checks++; if (bus32.ALU_result !== 32'd7) begin errors++; $display("FAIL rmid_pre: got %h expected 7", bus32.ALU_result); end
        send32(OP_DIVU, 32'd100, 32'd7, 1'b0);
        for (int k = 1; k < 10; k++) begin
            if (bus32.done !== 1'b0 || bus32.busy !== 1'b1) quiet = 1'b0;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL rmid_inflight: got %b expected 1", quiet); end
        checks++; if (bus32.ALU_result !== 32'h0 || bus32.branch !== 1'b0) begin
            errors++; $display("FAIL rmid_outputs: got %h/%b expected 0/0", bus32.ALU_result, bus32.branch);
        end
        checks++; if (bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin
            errors++; $display("FAIL rmid_handshake: busy %b done %b expected 0/0", bus32.busy, bus32.done);
        end
        quiet = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (bus32.done !== 1'b0) quiet = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL rmid_no_done: got %b expected 1", quiet); end
        send32(OP_ADD, 32'd1, 32'd1, 1'b0);
        checks++; if (bus32.done !== 1'b1 || bus32.ALU_result !== 32'd2) begin
            errors++; $display("FAIL rmid_after: done %b result %h expected 1/2", bus32.done, bus32.ALU_result);
        end
    endtask

    task automatic test_width16;
        int   lat;
        logic bok;
        send16(OP_MUL, 16'hFFFF, 16'h3);
        wait16(lat, bok);
        checks++; if (lat !== 18) begin errors++; $display("FAIL w16_mul_latency: got %0d expected 18", lat); end
        checks++; if (bus16.ALU_result !== 16'hFFFD) begin errors++; $display("FAIL w16_mul: got %h expected fffd", bus16.ALU_result); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL w16_busy: got %b expected 1", bok); end
        send16(OP_MULHU, 16'hFFFF, 16'h3);
        wait16(lat, bok);
        checks++; if (lat !== 18 || bus16.ALU_result !== 16'h0002) begin
            errors++; $display("FAIL w16_mulhu: lat %0d result %h expected 18/0002", lat, bus16.ALU_result);
        end
        send16(OP_DIV, 16'hFFF9, 16'h2);
        wait16(lat, bok);
        checks++; if (lat !== 18 || bus16.ALU_result !== 16'hFFFD) begin
            errors++; $display("FAIL w16_div: lat %0d result %h expected 18/fffd", lat, bus16.ALU_result);
        end
    endtask

    initial begin
        bus32.start = 1'b0; bus32.ALU_Control = '0; bus32.operand_A = '0; bus32.operand_B = '0; bus32.branch_op = 1'b0;
        bus16.start = 1'b0; bus16.ALU_Control = '0; bus16.operand_A = '0; bus16.operand_B = '0; bus16.branch_op = 1'b0;
        test_reset();
        test_add();
        test_single();
        test_back_to_back();
        test_mul_div();
        test_reset_mid_op();
        test_width16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
